// File: rtl/spi_master_ctrl.sv
// Command-level SPI master: turns {cmd, payload} into an SS_n/MOSI frame and captures the MISO reply byte.
// Optional abort/aborted port pair is built when SPI_MASTER_ABORT_EN is defined.
module spi_master_ctrl #(
  parameter int unsigned READ_GAP = 3,
  parameter int unsigned GUARD    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] cmd,
  input  logic [7:0] wdata,
`ifdef SPI_MASTER_ABORT_EN
  input  logic       abort,
  output logic       aborted,
`endif
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned FRAME_W = 10;
  localparam int unsigned BYTE_W  = 8;

  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(READ_GAP - 1);
  localparam logic [CNT_W-1:0] RECV_LAST  = CNT_W'(BYTE_W - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_SELECT,
    S_DECIDE,
    S_SHIFT,
    S_TAIL,
    S_WAIT_RD,
    S_RECV,
    S_CLOSE,
    S_GUARD
  } state_e;

  state_e               state_q;
  logic [FRAME_W-1:0]   frame_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [BYTE_W-1:0]    rx_q;
  logic [BYTE_W-1:0]    rdata_q;
  logic                 rd_cmd_q;
  logic                 ss_n_q;
  logic                 mosi_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 abort_hit;

  // Abort is honoured only while a frame is on the wire (not in IDLE or the guard window).
`ifdef SPI_MASTER_ABORT_EN
  logic aborted_q;
  assign abort_hit = abort && (state_q != S_IDLE) && (state_q != S_GUARD);
  assign aborted   = aborted_q;
`else
  assign abort_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      frame_q   <= '0;
      cnt_q     <= '0;
      rx_q      <= '0;
      rdata_q   <= '0;
      rd_cmd_q  <= 1'b0;
      ss_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SPI_MASTER_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      done_q    <= 1'b0;
`ifdef SPI_MASTER_ABORT_EN
      aborted_q <= 1'b0;
`endif
      if (abort_hit) begin
        ss_n_q    <= 1'b1;
        mosi_q    <= 1'b0;
        cnt_q     <= '0;
        state_q   <= S_GUARD;
`ifdef SPI_MASTER_ABORT_EN
        aborted_q <= 1'b1;
`endif
      end else begin
        unique case (state_q)
          S_IDLE: begin
            ss_n_q <= 1'b1;
            mosi_q <= 1'b0;
            if (start) begin
              frame_q  <= {cmd, (cmd == 2'b11) ? 8'h00 : wdata};
              rd_cmd_q <= (cmd == 2'b11);
              busy_q   <= 1'b1;
              state_q  <= S_SELECT;
            end
          end
          S_SELECT: begin
            ss_n_q  <= 1'b0;
            mosi_q  <= 1'b0;
            state_q <= S_DECIDE;
          end
          // frame_q[9] is cmd[1], which doubles as the slave's write/read decision bit.
          S_DECIDE: begin
            mosi_q  <= frame_q[FRAME_W-1];
            cnt_q   <= '0;
            state_q <= S_SHIFT;
          end
          S_SHIFT: begin
            mosi_q  <= frame_q[FRAME_W-1];
            frame_q <= {frame_q[FRAME_W-2:0], 1'b0};
            if (cnt_q == SHIFT_LAST) begin
              cnt_q   <= '0;
              state_q <= S_TAIL;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          S_TAIL: begin
            mosi_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= rd_cmd_q ? S_WAIT_RD : S_CLOSE;
          end
          S_WAIT_RD: begin
            mosi_q <= 1'b0;
            if (cnt_q == GAP_LAST) begin
              cnt_q   <= '0;
              state_q <= S_RECV;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          S_RECV: begin
            rx_q <= {rx_q[BYTE_W-2:0], MISO};
            if (cnt_q == RECV_LAST) begin
              cnt_q   <= '0;
              state_q <= S_CLOSE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          S_CLOSE: begin
            ss_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
            done_q  <= 1'b1;
            if (rd_cmd_q) begin
              rdata_q <= rx_q;
            end
            cnt_q   <= '0;
            state_q <= S_GUARD;
          end
          // The CLOSE (or abort) cycle is the first guard cycle; busy drops on the last one.
          S_GUARD: begin
            ss_n_q <= 1'b1;
            mosi_q <= 1'b0;
            if (cnt_q == GUARD_LAST) begin
              busy_q  <= 1'b0;
              cnt_q   <= '0;
              state_q <= S_IDLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign rdata = rdata_q;
  assign SS_n  = ss_n_q;
  assign MOSI  = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: frame table, reset/abort sequences and random frames
// checked cycle by cycle against a timing model derived from the edge numbering of a frame.
module tb_spi_master_ctrl;

  localparam int unsigned READ_GAP = 3;
  localparam int unsigned GUARD    = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] cmd;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
`ifdef SPI_MASTER_ABORT_EN
  logic       abort;
  logic       aborted;
`endif

  int         total = 0;
  int         bad   = 0;
  logic [7:0] model_rdata;

  always #5 clk = ~clk;

  spi_master_ctrl #(.READ_GAP(READ_GAP), .GUARD(GUARD)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .cmd   (cmd),
    .wdata (wdata),
`ifdef SPI_MASTER_ABORT_EN
    .abort   (abort),
    .aborted (aborted),
`endif
    .busy  (busy),
    .done  (done),
    .rdata (rdata),
    .SS_n  (SS_n),
    .MOSI  (MOSI),
    .MISO  (MISO)
  );

  // Observed vector: {aborted, SS_n, MOSI, busy, done, rdata}
  function automatic logic [12:0] obs();
`ifdef SPI_MASTER_ABORT_EN
    return {aborted, SS_n, MOSI, busy, done, rdata};
`else
    return {1'b0, SS_n, MOSI, busy, done, rdata};
`endif
  endfunction

  function automatic logic [12:0] vec(logic ab, logic ss, logic mo, logic bz, logic dn, logic [7:0] rd);
    return {ab, ss, mo, bz, dn, rd};
  endfunction

  function automatic int last_low(logic [1:0] c);
    return (c == 2'b11) ? 13 + int'(READ_GAP) + 8 : 13;
  endfunction

  // Expected outputs after edge Ek of a frame accepted at E0.
  function automatic logic [12:0] expv(int k, logic [1:0] c, logic [7:0] w, logic [7:0] mb,
                                       logic [7:0] prev);
    int         last;
    logic [9:0] fr;
    logic       mo;
    last = last_low(c);
    fr   = {c, (c == 2'b11) ? 8'h00 : w};
    mo   = 1'b0;
    if (k == 2) mo = c[1];
    else if (k >= 3 && k <= 12) mo = fr[12 - k];
    return vec(1'b0, !(k >= 1 && k <= last), mo, (k < last + 1 + int'(GUARD)), (k == last + 1),
               (c == 2'b11 && k >= last + 1) ? mb : prev);
  endfunction

  // MISO value the slave presents before edge Ej.
  function automatic logic miso_for(int j, logic [1:0] c, logic [7:0] mb);
    int   first;
    logic junk;
    first = 13 + int'(READ_GAP) + 1;
    junk  = 1'($urandom);
    if (c == 2'b11 && j >= first && j <= first + 7) return mb[7 - (j - first)];
    return junk;
  endfunction

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got {ab,ss,mosi,busy,done,rdata}=%b_%b_%b_%b_%b_%h expected %b_%b_%b_%b_%b_%h",
               name, act[12], act[11], act[10], act[9], act[8], act[7:0],
               exp[12], exp[11], exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  // Called just after a negedge with the DUT idle; stop_k < 0 runs the whole frame.
  task automatic run_frame(input logic [1:0] c, input logic [7:0] w, input logic [7:0] mb,
                           input bit hold, input int stop_k);
    int kend;
    kend  = last_low(c) + 1 + int'(GUARD);
    if (stop_k >= 0) kend = stop_k;
    start = 1'b1;
    cmd   = c;
    wdata = w;
    MISO  = 1'($urandom);
    for (int k = 0; k <= kend; k++) begin
      @(negedge clk);
      check($sformatf("frame cmd=%0d w=%h k=%0d", c, w, k), obs(), expv(k, c, w, mb, model_rdata));
      if (hold) begin
        start = 1'b1;
        cmd   = c;
        wdata = w;
      end else begin
        start = (k == kend) ? 1'b0 : 1'($urandom);
        cmd   = 2'($urandom);
        wdata = 8'($urandom);
      end
      MISO = miso_for(k + 1, c, mb);
    end
    if (stop_k < 0 && c == 2'b11) model_rdata = mb;
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      cmd   = 2'($urandom);
      wdata = 8'($urandom);
      MISO  = 1'($urandom);
      @(negedge clk);
      check($sformatf("idle %0d", i), obs(), vec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, model_rdata));
    end
  endtask

  task automatic hold_reset(input int n, input string name);
    rst   = 1'b1;
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check($sformatf("%s cyc %0d", name, i), obs(), vec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00));
    end
    model_rdata = 8'h00;
    rst = 1'b0;
  endtask

  typedef struct {
    logic [1:0] c;
    logic [7:0] w;
    logic [7:0] mb;
    bit         hold;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{2'b00, 8'h5A, 8'h00, 1'b0, 8'h00};
    tbl[1] = '{2'b01, 8'hC3, 8'h00, 1'b0, 8'h00};
    tbl[2] = '{2'b10, 8'h5A, 8'h00, 1'b0, 8'h00};
    tbl[3] = '{2'b11, 8'h00, 8'hC3, 1'b0, 8'hC3};
    tbl[4] = '{2'b00, 8'hFF, 8'h00, 1'b1, 8'hC3};
    tbl[5] = '{2'b00, 8'h00, 8'h00, 1'b1, 8'hC3};
    tbl[6] = '{2'b11, 8'hFF, 8'h81, 1'b0, 8'h81};
    tbl[7] = '{2'b01, 8'h01, 8'h00, 1'b0, 8'h81};

    rst   = 1'b1;
    start = 1'b0;
    cmd   = 2'b00;
    wdata = 8'h00;
    MISO  = 1'b0;
`ifdef SPI_MASTER_ABORT_EN
    abort = 1'b0;
`endif
    model_rdata = 8'h00;
    hold_reset(3, "power-on reset");
    idle(2);

    // Table: writes, read address/data, back-to-back held start, ignored wdata on read-data.
    for (int i = 0; i < 8; i++) begin
      run_frame(tbl[i].c, tbl[i].w, tbl[i].mb, tbl[i].hold, -1);
      total++;
      if (rdata !== tbl[i].exp_rdata) begin
        bad++;
        $display("FAIL tbl[%0d] rdata: got %h expected %h", i, rdata, tbl[i].exp_rdata);
      end
    end
    idle(3);

    // Reset held for 5 cycles in the middle of SHIFT.
    run_frame(2'b00, 8'h5A, 8'h00, 1'b0, 6);
    hold_reset(5, "reset mid-shift");
    idle(3);

    // Reset during RECV of a read-data frame: no done, next read still correct.
    run_frame(2'b11, 8'h00, 8'hA5, 1'b0, -1);
    run_frame(2'b11, 8'h00, 8'h3C, 1'b0, 20);
    hold_reset(1, "reset mid-recv");
    idle(4);
    run_frame(2'b11, 8'h00, 8'h77, 1'b0, -1);
    idle(1);

`ifdef SPI_MASTER_ABORT_EN
    // Abort during SHIFT: SS_n rises on the next edge, guard window follows, no done.
    run_frame(2'b01, 8'h5A, 8'h00, 1'b0, 6);
    abort = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check("abort edge", obs(), vec(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, model_rdata));
    abort = 1'b0;
    start = 1'b1;
    cmd   = 2'b00;
    @(negedge clk);
    check("abort guard", obs(), vec(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, model_rdata));
    @(negedge clk);
    check("abort guard end", obs(), vec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, model_rdata));
    start = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    check("abort in idle", obs(), vec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, model_rdata));
    abort = 1'b0;
    run_frame(2'b11, 8'h00, 8'h5E, 1'b0, -1);
    idle(1);
`endif

    // Random frames against the timing model.
    for (int n = 0; n < 30; n++) begin
      logic [1:0] c;
      logic [7:0] w;
      logic [7:0] mb;
      bit         h;
      c  = 2'($urandom_range(0, 3));
      w  = 8'($urandom);
      mb = 8'($urandom);
      h  = (n == 29) ? 1'b0 : 1'($urandom_range(0, 1));
      run_frame(c, w, mb, h, -1);
      if (!h) idle(int'($urandom_range(0, 3)));
    end
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
